// File: rtl/spi_frame_shifter_if.sv
// Bundles the conditioned serial inputs, the parallel transmit word and
// the received-word outputs of spi_frame_shifter.
// master: the side producing the conditioned inputs and tx_data.
// slave:  the frame shifter itself.
interface spi_frame_shifter_if #(
    parameter int width = 8
);
    logic             cs_n;
    logic             sclk_pe;
    logic             sclk_ne;
    logic             mosi;
    logic [width-1:0] tx_data;
    logic             miso;
    logic [width-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    logic             frame_err;

    modport master (
        output cs_n, sclk_pe, sclk_ne, mosi, tx_data,
        input  miso, rx_data, rx_valid, busy, frame_err
    );

    modport slave (
        input  cs_n, sclk_pe, sclk_ne, mosi, tx_data,
        output miso, rx_data, rx_valid, busy, frame_err
    );
endinterface

// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: assembles one MSB-first frame per chip-select assertion
// from conditioned serial-clock edge pulses, shifting tx_data out on miso in
// the same frame. Every output is a flop; there is no input-to-output path.
// Optional feature macro FRAME_PARITY_EN: appends an odd-parity bit to the
// frame in both directions; a bad received parity raises frame_err instead of
// rx_valid.
module spi_frame_shifter #(
    parameter int width = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_frame_shifter_if.slave   bus
);
`ifdef FRAME_PARITY_EN
    localparam int frame_len = width + 1;
`else
    localparam int frame_len = width;
`endif
    localparam int cnt_w = $clog2(width + 2);

    typedef logic [cnt_w-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    localparam cnt_t last_idx = cnt_t'(frame_len - 1);

    state_t               state, state_next;
    cnt_t                 cnt, cnt_next;
    logic [frame_len-1:0] tx_sr, tx_sr_next;
    logic [frame_len-1:0] rx_sr, rx_sr_next;
    logic [width-1:0]     rx_data_q, rx_data_next;
    logic                 miso_q, miso_next;
    logic                 rx_valid_q, rx_valid_next;
    logic                 busy_q, busy_next;
    logic                 frame_err_q, frame_err_next;

    logic [frame_len-1:0] tx_load;
    logic [frame_len-1:0] tx_shift;
    logic [frame_len-1:0] rx_shift;

    // Word loaded into the transmit shifter at frame start
`ifdef FRAME_PARITY_EN
    assign tx_load = {bus.tx_data, ~^bus.tx_data};
`else
    assign tx_load = bus.tx_data;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        // NOTE: the shift registers and rx_data are cleared on reset as well,
        // so an interrupted frame leaves no stale bits behind.
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state       <= state_next;
            cnt         <= cnt_next;
            tx_sr       <= tx_sr_next;
            rx_sr       <= rx_sr_next;
            rx_data_q   <= rx_data_next;
            miso_q      <= miso_next;
            rx_valid_q  <= rx_valid_next;
            busy_q      <= busy_next;
            frame_err_q <= frame_err_next;
        end
    end

    // Next-state, shifting and strobe generation
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_next     = state;
        cnt_next       = cnt;
        tx_sr_next     = tx_sr;
        rx_sr_next     = rx_sr;
        rx_data_next   = rx_data_q;
        miso_next      = miso_q;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;

        tx_shift    = tx_sr << 1;
        rx_shift    = rx_sr << 1;
        rx_shift[0] = bus.mosi;

        case (state)
            IDLE: begin
                miso_next = 1'b0;
                if (!bus.cs_n) begin
                    tx_sr_next = tx_load;
                    miso_next  = tx_load[frame_len-1];
                    cnt_next   = '0;
                    rx_sr_next = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (bus.cs_n) begin
                    // Chip select lost mid-frame: abort, even over a final edge
                    state_next     = IDLE;
                    miso_next      = 1'b0;
                    frame_err_next = 1'b1;
                end else if (bus.sclk_pe) begin
                    // Rising edge wins over a coincident falling edge
                    rx_sr_next = rx_shift;
                    cnt_next   = cnt + cnt_t'(1);
                    if (cnt == last_idx) begin
                        state_next = HOLD;
                        miso_next  = 1'b0;
`ifdef FRAME_PARITY_EN
                        if (^rx_shift) begin
                            rx_data_next  = rx_shift[frame_len-1 -: width];
                            rx_valid_next = 1'b1;
                        end else begin
                            frame_err_next = 1'b1;
                        end
`else
                        rx_data_next  = rx_shift;
                        rx_valid_next = 1'b1;
`endif
                    end
                end else if (bus.sclk_ne && cnt != '0) begin
                    // A falling edge before any rising edge is a leading edge
                    tx_sr_next = tx_shift;
                    miso_next  = tx_shift[frame_len-1];
                end
            end

            HOLD: begin
                miso_next = 1'b0;
                if (bus.cs_n) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                miso_next  = 1'b0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.miso      = miso_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;

endmodule
